// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_tx
// Description : Parallel-to-serial stimulus transmitter for the "every second
//               one" detector. Takes a WIDTH-bit word over valid/ready, shifts
//               it out MSB-first one bit per clock, then idles for GAP cycles.
//               Define SERIAL_PATTERN_TX_PREDICT_EN to build the cycle-accurate
//               predictor of the detector's dout on exp_dout; otherwise
//               exp_dout is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             done,
    output logic             exp_dout
);

    // Counter widths; the gap counter keeps one bit even when GAP==0 so the
    // declaration stays legal (it is simply never loaded in that build).
    localparam int c_BW = $clog2(WIDTH);
    localparam int c_GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [c_BW-1:0] c_BIT_LOAD = c_BW'(WIDTH - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = '0;
    localparam logic [c_BW-1:0] c_BIT_ONE  = c_BW'(1);
    localparam logic [c_GW-1:0] c_GAP_LOAD = c_GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [c_GW-1:0] c_GAP_LAST = '0;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    logic [1:0]       r_state,   w_state_nxt;
    logic [WIDTH-1:0] r_shreg,   w_shreg_nxt;
    logic [c_BW-1:0]  r_bitcnt,  w_bitcnt_nxt;
    logic [c_GW-1:0]  r_gapcnt,  w_gapcnt_nxt;
    logic             r_ser_out, w_ser_out_nxt;
    logic             r_ser_en,  w_ser_en_nxt;
    logic             r_done,    w_done_nxt;

    // State and datapath registers; reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_gapcnt  <= '0;
            r_ser_out <= 1'b0;
            r_ser_en  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_gapcnt  <= w_gapcnt_nxt;
            r_ser_out <= w_ser_out_nxt;
            r_ser_en  <= w_ser_en_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and next-output decode; outputs are precomputed one cycle
    // ahead so every port comes straight from a flop.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bitcnt_nxt  = r_bitcnt;
        w_gapcnt_nxt  = r_gapcnt;
        w_ser_out_nxt = 1'b0;
        w_ser_en_nxt  = 1'b0;
        w_done_nxt    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (valid) begin
                    w_state_nxt   = c_ST_SHIFT;
                    w_shreg_nxt   = data_in;
                    w_bitcnt_nxt  = c_BIT_LOAD;
                    w_ser_out_nxt = data_in[WIDTH-1];
                    w_ser_en_nxt  = 1'b1;
                end
            end

            c_ST_SHIFT: begin
                // Rotate rather than shift so no shreg bit goes unread; the
                // wrapped-around MSB is never put on the line.
                w_shreg_nxt = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
                if (r_bitcnt == c_BIT_LAST) begin
                    if (GAP > 0) begin
                        w_state_nxt  = c_ST_GAP;
                        w_gapcnt_nxt = c_GAP_LOAD;
                    end else begin
                        w_state_nxt  = c_ST_IDLE;
                    end
                end else begin
                    w_bitcnt_nxt  = r_bitcnt - c_BIT_ONE;
                    w_ser_out_nxt = r_shreg[WIDTH-2];
                    w_ser_en_nxt  = 1'b1;
                    w_done_nxt    = (r_bitcnt == c_BIT_ONE);
                end
            end

            c_ST_GAP: begin
                if (r_gapcnt == c_GAP_LAST) begin
                    w_state_nxt  = c_ST_IDLE;
                end else begin
                    w_gapcnt_nxt = r_gapcnt - c_GW'(1);
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign ready   = (r_state == c_ST_IDLE);
    assign ser_out = r_ser_out;
    assign ser_en  = r_ser_en;
    assign done    = r_done;

`ifdef SERIAL_PATTERN_TX_PREDICT_EN
    logic r_parity;

    // Parity of ones sent so far mirrors the detector's two-state FSM; it is
    // held through gaps because ser_out is 0 there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= r_parity ^ r_ser_out;
        end
    end

    assign exp_dout = r_parity & r_ser_out;
`else
    assign exp_dout = 1'b0;
`endif

endmodule
`default_nettype wire
